// File: rtl/uart_pkg.sv
// Shared UART definitions: baud divisor, command-assembler timeout default and FSM state type.
package uart_pkg;

  localparam int unsigned BAUD_CYC    = 2604;
  localparam int unsigned TMO_CYC_DEF = 130000;

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_LO = 1'b1
  } cmd_asm_state_t;

endpackage

// File: rtl/uart_cmd_asm_if.sv
// Byte-in / command-out handshake bundle between UART receiver, assembler and command controller.
interface uart_cmd_asm_if;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        frm_err;
  logic        overrun;

  // master: the assembler itself
  modport master (
    input  rx_rdy, rx_data, clr_cmd_rdy,
    output clr_rx_rdy, cmd, cmd_rdy, frm_err, overrun
  );

  // slave: receiver plus command controller seen from the assembler
  modport slave (
    output rx_rdy, rx_data, clr_cmd_rdy,
    input  clr_rx_rdy, cmd, cmd_rdy, frm_err, overrun
  );
endinterface

// File: rtl/uart_cmd_asm.sv
// Pairs received UART bytes into 16-bit commands (high byte first) with an inter-byte
// timeout that resynchronises framing and flags frm_err.
module uart_cmd_asm
  import uart_pkg::*;
#(
  parameter int unsigned TMO_CYC = TMO_CYC_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_cmd_asm_if.master bus
);

  localparam int unsigned    CNT_W    = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  cmd_asm_state_t   state, state_d;
  logic             rx_rdy_q;
  logic [7:0]       hi_byte, hi_byte_d;
  logic [CNT_W-1:0] tmo_cnt, tmo_cnt_d;
  logic [15:0]      cmd_d;
  logic             accept;
  logic             complete;
  logic             timeout;

  // Rising edge of the receiver's level-style ready; a held level is consumed once.
  assign accept = bus.rx_rdy & ~rx_rdy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d   = state;
    hi_byte_d = hi_byte;
    tmo_cnt_d = tmo_cnt;
    cmd_d     = bus.cmd;
    complete  = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        tmo_cnt_d = '0;
        if (accept) begin
          hi_byte_d = bus.rx_data;
          state_d   = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (tmo_cnt != CNT_MAX) tmo_cnt_d = tmo_cnt + CNT_W'(1);
        // A low byte arriving in the timeout cycle still completes the command.
        if (accept) begin
          cmd_d     = {hi_byte, bus.rx_data};
          complete  = 1'b1;
          tmo_cnt_d = '0;
          state_d   = IDLE;
        end else if (tmo_cnt == CNT_LAST) begin
          hi_byte_d = '0;
          timeout   = 1'b1;
          tmo_cnt_d = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered handshake outputs; set beats clear on cmd_rdy/overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_rdy_q       <= 1'b0;
      hi_byte        <= '0;
      tmo_cnt        <= '0;
      bus.clr_rx_rdy <= 1'b0;
      bus.cmd        <= '0;
      bus.cmd_rdy    <= 1'b0;
      bus.frm_err    <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      rx_rdy_q       <= bus.rx_rdy;
      hi_byte        <= hi_byte_d;
      tmo_cnt        <= tmo_cnt_d;
      bus.clr_rx_rdy <= accept;
      bus.cmd        <= cmd_d;
      bus.cmd_rdy    <= complete | (bus.cmd_rdy & ~bus.clr_cmd_rdy);
      bus.frm_err    <= timeout;
      bus.overrun    <= (complete & bus.cmd_rdy & ~bus.clr_cmd_rdy)
                      | (bus.overrun & ~bus.clr_cmd_rdy);
    end
  end

endmodule

// File: tb/tb_uart_cmd_asm.sv
// Directed self-checking bench for uart_cmd_asm with a short inter-byte timeout.
module tb_uart_cmd_asm;

  localparam int unsigned TMO = 64;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   clr_cnt;
  int   frm_cnt;

  uart_cmd_asm_if bus ();

  uart_cmd_asm #(.TMO_CYC(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count high cycles of the pulse outputs, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.clr_rx_rdy) clr_cnt = clr_cnt + 1;
      if (bus.frm_err)    frm_cnt = frm_cnt + 1;
    end
  end

  // One-cycle rx_rdy pulse; returns #1 into the cycle after the edge.
  task automatic send_byte(input logic [7:0] d);
    @(posedge clk); #1;
    bus.rx_rdy  = 1'b1;
    bus.rx_data = d;
    @(posedge clk); #1;
    bus.rx_rdy  = 1'b0;
  endtask

  task automatic ack_cmd();
    @(posedge clk); #1;
    bus.clr_cmd_rdy = 1'b1;
    @(posedge clk); #1;
    bus.clr_cmd_rdy = 1'b0;
    total++; if (bus.cmd_rdy !== 1'b0) begin bad++; $display("FAIL ack_cmd_rdy got=%b want=0", bus.cmd_rdy); end
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL ack_overrun got=%b want=0", bus.overrun); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.rx_rdy = 1'b0; bus.rx_data = 8'h00; bus.clr_cmd_rdy = 1'b0;
    clr_cnt = 0; frm_cnt = 0;
    #2;
    total++; if (bus.cmd !== 16'h0000) begin bad++; $display("FAIL reset_cmd got=%h want=0000", bus.cmd); end
    total++; if (bus.cmd_rdy !== 1'b0) begin bad++; $display("FAIL reset_cmd_rdy got=%b want=0", bus.cmd_rdy); end
    total++; if (bus.clr_rx_rdy !== 1'b0) begin bad++; $display("FAIL reset_clr_rx_rdy got=%b want=0", bus.clr_rx_rdy); end
    total++; if (bus.frm_err !== 1'b0) begin bad++; $display("FAIL reset_frm_err got=%b want=0", bus.frm_err); end
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", bus.overrun); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_nominal();
    clr_cnt = 0;
    send_byte(8'hA5);
    total++; if (bus.clr_rx_rdy !== 1'b1) begin bad++; $display("FAIL nom_clr_hi got=%b want=1", bus.clr_rx_rdy); end
    total++; if (bus.cmd_rdy !== 1'b0) begin bad++; $display("FAIL nom_rdy_early got=%b want=0", bus.cmd_rdy); end
    send_byte(8'h3C);
    total++; if (bus.cmd !== 16'hA53C) begin bad++; $display("FAIL nom_cmd got=%h want=a53c", bus.cmd); end
    total++; if (bus.cmd_rdy !== 1'b1) begin bad++; $display("FAIL nom_cmd_rdy got=%b want=1", bus.cmd_rdy); end
    repeat (4) @(posedge clk); #1;
    total++; if (clr_cnt !== 2) begin bad++; $display("FAIL nom_clr_cycles got=%0d want=2", clr_cnt); end
    total++; if (bus.cmd_rdy !== 1'b1) begin bad++; $display("FAIL nom_rdy_hold got=%b want=1", bus.cmd_rdy); end
    ack_cmd();
    total++; if (bus.cmd !== 16'hA53C) begin bad++; $display("FAIL nom_cmd_hold got=%h want=a53c", bus.cmd); end
  endtask

  task automatic test_level_hold();
    clr_cnt = 0; frm_cnt = 0;
    @(posedge clk); #1;
    bus.rx_rdy = 1'b1; bus.rx_data = 8'h11;
    repeat (50) @(posedge clk); #1;
    bus.rx_rdy = 1'b0;
    @(posedge clk); #1;
    bus.rx_rdy = 1'b1; bus.rx_data = 8'h22;
    repeat (3) @(posedge clk); #1;
    bus.rx_rdy = 1'b0;
    repeat (2) @(posedge clk); #1;
    total++; if (clr_cnt !== 2) begin bad++; $display("FAIL hold_clr_cycles got=%0d want=2", clr_cnt); end
    total++; if (bus.cmd !== 16'h1122) begin bad++; $display("FAIL hold_cmd got=%h want=1122", bus.cmd); end
    total++; if (frm_cnt !== 0) begin bad++; $display("FAIL hold_frm got=%0d want=0", frm_cnt); end
    ack_cmd();
  endtask

  task automatic test_timeout();
    frm_cnt = 0;
    send_byte(8'h12);
    repeat (TMO - 1) @(posedge clk); #1;
    total++; if (bus.frm_err !== 1'b0) begin bad++; $display("FAIL tmo_early got=%b want=0", bus.frm_err); end
    @(posedge clk); #1;
    total++; if (bus.frm_err !== 1'b1) begin bad++; $display("FAIL tmo_pulse got=%b want=1", bus.frm_err); end
    @(posedge clk); #1;
    total++; if (bus.frm_err !== 1'b0) begin bad++; $display("FAIL tmo_width got=%b want=0", bus.frm_err); end
    send_byte(8'h34);
    send_byte(8'h56);
    total++; if (bus.cmd !== 16'h3456) begin bad++; $display("FAIL tmo_resync got=%h want=3456", bus.cmd); end
    total++; if (frm_cnt !== 1) begin bad++; $display("FAIL tmo_count got=%0d want=1", frm_cnt); end
    ack_cmd();
  endtask

  task automatic test_timeout_race();
    frm_cnt = 0;
    send_byte(8'h77);
    repeat (TMO - 1) @(posedge clk); #1;
    bus.rx_rdy = 1'b1; bus.rx_data = 8'h88;
    @(posedge clk); #1;
    bus.rx_rdy = 1'b0;
    total++; if (bus.cmd !== 16'h7788) begin bad++; $display("FAIL race_cmd got=%h want=7788", bus.cmd); end
    total++; if (bus.cmd_rdy !== 1'b1) begin bad++; $display("FAIL race_rdy got=%b want=1", bus.cmd_rdy); end
    repeat (3) @(posedge clk); #1;
    total++; if (frm_cnt !== 0) begin bad++; $display("FAIL race_frm got=%0d want=0", frm_cnt); end
    ack_cmd();
  endtask

  task automatic test_overrun();
    send_byte(8'hAB);
    send_byte(8'hCD);
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL ovr_first got=%b want=0", bus.overrun); end
    send_byte(8'h12);
    send_byte(8'h34);
    total++; if (bus.cmd !== 16'h1234) begin bad++; $display("FAIL ovr_cmd got=%h want=1234", bus.cmd); end
    total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b want=1", bus.overrun); end
    ack_cmd();
    send_byte(8'h5A);
    send_byte(8'hA5);
    // low byte of the next pair arrives together with the acknowledge
    send_byte(8'h66);
    @(posedge clk); #1;
    bus.rx_rdy = 1'b1; bus.rx_data = 8'h99; bus.clr_cmd_rdy = 1'b1;
    @(posedge clk); #1;
    bus.rx_rdy = 1'b0; bus.clr_cmd_rdy = 1'b0;
    total++; if (bus.cmd_rdy !== 1'b1) begin bad++; $display("FAIL coinc_rdy got=%b want=1", bus.cmd_rdy); end
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL coinc_ovr got=%b want=0", bus.overrun); end
    total++; if (bus.cmd !== 16'h6699) begin bad++; $display("FAIL coinc_cmd got=%h want=6699", bus.cmd); end
    ack_cmd();
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'h0A);
    send_byte(8'h0B);
    send_byte(8'h0C);
    send_byte(8'h0D);
    send_byte(8'hFF);
    rst_n = 1'b0;
    #2;
    total++; if (bus.cmd !== 16'h0000) begin bad++; $display("FAIL rmid_cmd got=%h want=0000", bus.cmd); end
    total++; if (bus.cmd_rdy !== 1'b0) begin bad++; $display("FAIL rmid_rdy got=%b want=0", bus.cmd_rdy); end
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL rmid_ovr got=%b want=0", bus.overrun); end
    total++; if (bus.clr_rx_rdy !== 1'b0) begin bad++; $display("FAIL rmid_clr got=%b want=0", bus.clr_rx_rdy); end
    total++; if (bus.frm_err !== 1'b0) begin bad++; $display("FAIL rmid_frm got=%b want=0", bus.frm_err); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h01);
    send_byte(8'h02);
    total++; if (bus.cmd !== 16'h0102) begin bad++; $display("FAIL rmid_resync got=%h want=0102", bus.cmd); end
    total++; if (bus.cmd_rdy !== 1'b1) begin bad++; $display("FAIL rmid_resync_rdy got=%b want=1", bus.cmd_rdy); end
    ack_cmd();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_nominal();
    test_level_hold();
    test_timeout();
    test_timeout_race();
    test_overrun();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
